vram_scan_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two users: display scan-out reads, driven by the 640x480 VGA timing counters, and host pixel writes over a req/ack handshake.
- Display reads have fixed priority and a guaranteed slot in every pixel period. Host writes use all remaining slots.
- Sits between the VGA timing generator, the framebuffer RAM and the drawing logic.

---
 rtl/vram_scan_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_scan_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scan_arbiter.sv
// Shares a single-port video RAM between VGA scan-out fetches (fixed priority, one slot per pixel)
// and host pixel writes (all remaining slots). Optional macro VRAM_TEAR_FREE_EN gates host writes
// to vertical blanking.
module vram_scan_arbiter #(
  parameter int unsigned PIX_SHIFT = 2,
  parameter int unsigned FB_W      = 640 >> PIX_SHIFT,
  parameter int unsigned FB_H      = 480 >> PIX_SHIFT,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              update,
  input  logic [9:0]        vga_h_cnt,
  input  logic [9:0]        vga_v_cnt,
  input  logic              color_enable,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_en
);

  localparam logic [ADDR_W:0] FbSize = (ADDR_W + 1)'(FB_W * FB_H);

  typedef enum logic {StSlotA, StSlotB} phase_e;

  phase_e              phase_q, phase_d;
  logic                update_q;
  logic                tick;
  logic                slot_a;
  logic                fetch_pend_q, fetch_pend_d;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [DATA_W-1:0]   pixel_data_q, pixel_data_d;
  logic                pixel_en_q, pixel_en_d;
  logic [ADDR_W-1:0]   fetch_row, fetch_col, fetch_addr;
  logic                wr_oor;
  logic                host_window;

  assign tick = update & ~update_q;

  // The slot being entered this cycle; a tick cycle is itself slot A so that the
  // fetched pixel lands two mclk after the counters change.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      StSlotA: phase_d = StSlotB;
      StSlotB: if (tick) phase_d = StSlotA;
      default: phase_d = StSlotB;
    endcase
  end

  assign slot_a = (phase_d == StSlotA);

  assign fetch_row  = ADDR_W'(vga_v_cnt >> PIX_SHIFT);
  assign fetch_col  = ADDR_W'(vga_h_cnt >> PIX_SHIFT);
  assign fetch_addr = fetch_row * ADDR_W'(FB_W) + fetch_col;

  assign wr_oor = ({1'b0, wr_addr} >= FbSize);

`ifdef VRAM_TEAR_FREE_EN
  assign host_window = (vga_v_cnt >= 10'd480);
`else
  assign host_window = 1'b1;
`endif

  // RAM port mux: display fetch first, then host; address and data hold when idle.
  always_comb begin
    ram_addr     = ram_addr_q;
    ram_wdata    = ram_wdata_q;
    ram_we       = 1'b0;
    wr_ack       = 1'b0;
    wr_err       = 1'b0;
    fetch_pend_d = 1'b0;
    if (!rst) begin
      if (slot_a && color_enable) begin
        ram_addr     = fetch_addr;
        fetch_pend_d = 1'b1;
      end else if (wr_req && host_window) begin
        wr_ack = 1'b1;
        if (wr_oor) begin
          wr_err = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
      end
    end
  end

  always_comb begin
    pixel_data_d = pixel_data_q;
    pixel_en_d   = pixel_en_q;
    if (fetch_pend_q) begin
      pixel_data_d = ram_rdata;
      pixel_en_d   = 1'b1;
    end else if (slot_a && !color_enable) begin
      pixel_data_d = '0;
      pixel_en_d   = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      update_q     <= 1'b0;
      phase_q      <= StSlotA;
      fetch_pend_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      pixel_data_q <= '0;
      pixel_en_q   <= 1'b0;
    end else begin
      update_q     <= update;
      phase_q      <= phase_d;
      fetch_pend_q <= fetch_pend_d;
      ram_addr_q   <= ram_addr;
      ram_wdata_q  <= ram_wdata;
      pixel_data_q <= pixel_data_d;
      pixel_en_q   <= pixel_en_d;
    end
  end

  assign pixel_data = pixel_data_q;
  assign pixel_en   = pixel_en_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Bench for vram_scan_arbiter: drives VGA timing and host traffic, checks against a pixel-level model.
module tb_vram_scan_arbiter;
  localparam int AW     = 15;
  localparam int DW     = 8;
  localparam int FBW    = 160;
  localparam int FBSIZE = 19200;
`ifdef VRAM_TEAR_FREE_EN
  localparam logic [9:0] BLANK_V = 10'd490;
`else
  localparam logic [9:0] BLANK_V = 10'd10;
`endif

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic          update = 1'b0;
  logic [9:0]    vga_h_cnt = 10'd799;
  logic [9:0]    vga_v_cnt = 10'd524;
  logic          color_enable = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, wr_err, ram_we, pixel_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, pixel_data;
  logic [DW-1:0] ram_rdata = '0;

  int checks = 0;
  int failures = 0;

  vram_scan_arbiter dut (
    .mclk(mclk), .rst(rst), .update(update), .vga_h_cnt(vga_h_cnt), .vga_v_cnt(vga_v_cnt),
    .color_enable(color_enable), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pixel_data(pixel_data), .pixel_en(pixel_en)
  );

  always #5 mclk = ~mclk;

  // Framebuffer RAM, driven from DUT outputs sampled mid-cycle.
  logic [DW-1:0] mem [0:32767];
  logic          s_we = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;
  always @(negedge mclk) begin
    s_we    <= ram_we;
    s_addr  <= ram_addr;
    s_wdata <= ram_wdata;
  end
  always @(posedge mclk) begin
    if (s_we) mem[s_addr] <= s_wdata;
    ram_rdata <= mem[s_addr];
  end

  // Timing generator: update = mclk/2, counters step on its rising edge.
  logic       run_upd = 1'b1;
  logic       jump = 1'b0;
  logic [9:0] jh = '0, jv = '0;
  initial forever begin
    @(posedge mclk); #1;
    if (rst) begin
      update = 1'b0;
    end else if (run_upd) begin
      update = ~update;
      if (update) begin
        if (jump) begin
          vga_h_cnt = jh;
          vga_v_cnt = jv;
          jump = 1'b0;
        end else if (vga_h_cnt == 10'd799) begin
          vga_h_cnt = 10'd0;
          vga_v_cnt = (vga_v_cnt == 10'd524) ? 10'd0 : vga_v_cnt + 10'd1;
        end else begin
          vga_h_cnt = vga_h_cnt + 10'd1;
        end
        color_enable = (vga_h_cnt < 10'd640) && (vga_v_cnt < 10'd480);
      end
    end
  end

  // Reference model: per-cycle expectations from the arbitration rules.
  logic [DW-1:0] ref_mem [0:FBSIZE-1];
  logic          m_prev = 1'b0, m_pend = 1'b0, m_pen = 1'b0;
  logic [AW-1:0] m_last = '0, m_pend_addr = '0;
  logic [DW-1:0] m_pix = '0;
  logic          e_tick = 1'b0, e_fetch = 1'b0, e_ack = 1'b0, e_err = 1'b0, e_we = 1'b0;
  logic          e_pen = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_pix = '0;
  initial forever begin
    bit window;
    @(negedge mclk);
    if (rst) begin
      {m_prev, m_pend, m_pen, e_tick, e_fetch, e_ack, e_err, e_we, e_pen} = '0;
      m_last = '0;
      m_pix  = '0;
      e_addr = '0;
      e_pix  = '0;
    end else begin
      window = 1'b1;
`ifdef VRAM_TEAR_FREE_EN
      window = (vga_v_cnt >= 10'd480);
`endif
      e_pix   = m_pix;
      e_pen   = m_pen;
      e_tick  = update && !m_prev;
      e_fetch = e_tick && color_enable;
      e_ack   = !e_fetch && wr_req && window;
      e_err   = e_ack && (int'(wr_addr) >= FBSIZE);
      e_we    = e_ack && !e_err;
      if (e_fetch) e_addr = AW'((int'(vga_v_cnt) / 4) * FBW + int'(vga_h_cnt) / 4);
      else if (e_we) e_addr = wr_addr;
      else e_addr = m_last;
      m_last = e_addr;
      if (m_pend) begin
        m_pix = ref_mem[m_pend_addr];
        m_pen = 1'b1;
      end else if (e_tick && !color_enable) begin
        m_pix = '0;
        m_pen = 1'b0;
      end
      if (e_we) ref_mem[wr_addr] = wr_data;
      m_pend      = e_fetch;
      m_pend_addr = e_addr;
      m_prev      = update;
    end
  end

  logic [DW-1:0] pix0, pix_corner;

  task automatic wait_tick(input int max_cyc, input logic [9:0] want_h, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge mclk); #1;
      if (e_tick && vga_h_cnt == want_h) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge mclk);
    #1;
    wr_req = 1'b1; wr_addr = AW'(7); wr_data = 8'h5C;
    @(negedge mclk); #1;
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b want=0", wr_ack); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", wr_err); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b want=0", ram_we); end
    checks++; if (ram_addr !== '0) begin failures++; $display("FAIL rst_addr got=%0d want=0", ram_addr); end
    checks++; if (ram_wdata !== '0) begin failures++; $display("FAIL rst_wdata got=%h want=0", ram_wdata); end
    checks++; if (pixel_data !== '0) begin failures++; $display("FAIL rst_pix got=%h want=0", pixel_data); end
    checks++; if (pixel_en !== 1'b0) begin failures++; $display("FAIL rst_pen got=%b want=0", pixel_en); end
    @(posedge mclk); #1;
    wr_req = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_scan_origin();
    bit ok;
    wait_tick(10, 10'd0, ok);
    checks++; if (!ok || vga_v_cnt !== 10'd0) begin failures++; $display("FAIL origin_tick got=%b want=1", ok); end
    checks++; if (ram_addr !== AW'(0) || ram_we !== 1'b0) begin
      failures++; $display("FAIL origin_addr got=%0d we=%b want=0 we=0", ram_addr, ram_we);
    end
    @(negedge mclk); #1;
    checks++; if (pixel_en !== 1'b0) begin failures++; $display("FAIL origin_pen_early got=%b want=0", pixel_en); end
    @(negedge mclk); #1;
    checks++; if (pixel_data !== pix0) begin failures++; $display("FAIL origin_pix got=%h want=%h", pixel_data, pix0); end
    checks++; if (pixel_en !== 1'b1) begin failures++; $display("FAIL origin_pen got=%b want=1", pixel_en); end
  endtask

  task automatic test_scan_corner();
    bit ok;
    jh = 10'd639; jv = 10'd479; jump = 1'b1;
    wait_tick(10, 10'd639, ok);
    checks++; if (!ok) begin failures++; $display("FAIL corner_tick got=0 want=1"); end
    checks++; if (ram_addr !== AW'(19199)) begin failures++; $display("FAIL corner_addr got=%0d want=19199", ram_addr); end
    repeat (2) @(negedge mclk);
    #1;
    checks++; if (pixel_data !== pix_corner) begin
      failures++; $display("FAIL corner_pix got=%h want=%h", pixel_data, pix_corner);
    end
  endtask

  task automatic test_active_write();
    bit ok, got;
    int when;
    jh = 10'd100; jv = 10'd50; jump = 1'b1;
    wait_tick(10, 10'd100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL act_tick got=0 want=1"); end
    @(negedge mclk);
    @(posedge mclk); #1;
    wr_req = 1'b1; wr_addr = AW'(5); wr_data = 8'hA5;
    got = 1'b0; when = -1;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge mclk); #1;
      if (c == 0) begin
        checks++; if (wr_ack !== 1'b0 || ram_addr !== AW'((int'(vga_v_cnt) / 4) * FBW + int'(vga_h_cnt) / 4)) begin
          failures++; $display("FAIL act_fetch_slot ack=%b addr=%0d want ack=0 fetch", wr_ack, ram_addr);
        end
      end
      if (wr_ack) begin
        got = 1'b1; when = c;
        checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(5) || ram_wdata !== 8'hA5) begin
          failures++; $display("FAIL act_write we=%b addr=%0d data=%h want 1/5/a5", ram_we, ram_addr, ram_wdata);
        end
      end
      @(posedge mclk); #1;
      if (got) wr_req = 1'b0;
    end
    checks++; if (when !== 1) begin failures++; $display("FAIL act_ack_cycle got=%0d want=1", when); end
    repeat (2) @(negedge mclk);
    #1;
    checks++; if (mem[5] !== 8'hA5) begin failures++; $display("FAIL act_mem got=%h want=a5", mem[5]); end
    checks++; if (pixel_data !== e_pix || pixel_en !== 1'b1) begin
      failures++; $display("FAIL act_pix got=%h/%b want=%h/1", pixel_data, pixel_en, e_pix);
    end
  endtask

`ifdef VRAM_TEAR_FREE_EN
  task automatic test_tear_free();
    bit ok, got;
    jh = 10'd0; jv = 10'd100; jump = 1'b1;
    wait_tick(10, 10'd0, ok);
    @(posedge mclk); #1;
    wr_req = 1'b1; wr_addr = AW'(77); wr_data = 8'h3C;
    for (int c = 0; c < 30; c++) begin
      @(negedge mclk); #1;
      checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL tear_early_ack got=1 want=0"); end
    end
    jh = 10'd0; jv = 10'd480; jump = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge mclk); #1;
      if (wr_ack) begin
        got = 1'b1;
        checks++; if (vga_v_cnt < 10'd480 || ram_addr !== AW'(77)) begin
          failures++; $display("FAIL tear_ack v=%0d addr=%0d want v>=480 addr=77", vga_v_cnt, ram_addr);
        end
      end
      @(posedge mclk); #1;
      if (got) wr_req = 1'b0;
    end
    checks++; if (!got) begin failures++; $display("FAIL tear_timeout got=0 want=1"); end
  endtask
`endif

  task automatic test_blank_b2b();
    bit ok;
    int acks = 0, last = -10;
    jh = 10'd700; jv = BLANK_V; jump = 1'b1;
    wait_tick(10, 10'd700, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_tick got=0 want=1"); end
    for (int c = 0; c < 12 && acks < 4; c++) begin
      @(posedge mclk); #1;
      wr_req = 1'b1; wr_addr = AW'(100 + acks); wr_data = DW'(8'h30 + acks);
      @(negedge mclk); #1;
      if (wr_ack) begin
        checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(100 + acks)) begin
          failures++; $display("FAIL b2b_write we=%b addr=%0d want 1/%0d", ram_we, ram_addr, 100 + acks);
        end
        if (acks > 0) begin
          checks++; if (c - last !== 1) begin failures++; $display("FAIL b2b_gap got=%0d want=1", c - last); end
        end
        last = c;
        acks++;
      end
    end
    @(posedge mclk); #1;
    wr_req = 1'b0;
    checks++; if (acks !== 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", acks); end
  endtask

  task automatic test_oor();
    bit got = 1'b0;
    @(posedge mclk); #1;
    wr_req = 1'b1; wr_addr = AW'(19200); wr_data = 8'hEE;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge mclk); #1;
      if (wr_ack) begin
        got = 1'b1;
        checks++; if (wr_err !== 1'b1 || ram_we !== 1'b0) begin
          failures++; $display("FAIL oor_flags err=%b we=%b want 1/0", wr_err, ram_we);
        end
        checks++; if (ram_addr !== e_addr) begin failures++; $display("FAIL oor_addr got=%0d want=%0d", ram_addr, e_addr); end
      end
      @(posedge mclk); #1;
      if (got) wr_req = 1'b0;
    end
    checks++; if (!got) begin failures++; $display("FAIL oor_timeout got=0 want=1"); end
  endtask

  task automatic test_no_tick();
    int acks = 0;
    run_upd = 1'b0;
    repeat (2) @(posedge mclk);
    for (int c = 0; c < 6; c++) begin
      #1;
      wr_req = 1'b1; wr_addr = AW'(300 + acks); wr_data = DW'($urandom);
      @(negedge mclk); #1;
      if (wr_ack && ram_we) acks++;
      @(posedge mclk);
    end
    #1;
    wr_req = 1'b0;
    run_upd = 1'b1;
    checks++; if (acks !== 6) begin failures++; $display("FAIL notick_count got=%0d want=6", acks); end
  endtask

  task automatic test_reset_midflight();
    bit ok, got;
    jh = 10'd200; jv = 10'd60; jump = 1'b1;
    wait_tick(10, 10'd200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_tick got=0 want=1"); end
    @(posedge mclk); #2;
    rst = 1'b1; wr_req = 1'b1; wr_addr = AW'(9); wr_data = 8'h99;
    @(negedge mclk); #1;
    checks++; if (wr_ack !== 1'b0 || pixel_en !== 1'b0 || pixel_data !== '0 || ram_addr !== '0) begin
      failures++; $display("FAIL midrst_outs ack=%b pen=%b pix=%h addr=%0d want 0", wr_ack, pixel_en,
                           pixel_data, ram_addr);
    end
    repeat (2) @(posedge mclk);
    #2 rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge mclk); #1;
      if (c == 0) begin
        checks++; if (pixel_en !== 1'b0) begin failures++; $display("FAIL midrst_pen got=%b want=0", pixel_en); end
      end
      if (wr_ack) begin
        got = 1'b1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(9) || ram_wdata !== 8'h99) begin
          failures++; $display("FAIL midrst_write we=%b addr=%0d data=%h want 1/9/99", ram_we, ram_addr, ram_wdata);
        end
      end
      @(posedge mclk); #1;
      if (got) wr_req = 1'b0;
    end
    checks++; if (!got) begin failures++; $display("FAIL midrst_timeout got=0 want=1"); end
  endtask

  task automatic test_random();
    bit ack_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge mclk); #1;
      if (!wr_req || ack_prev) begin
        wr_req  = ($urandom_range(0, 2) != 0);
        wr_addr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(19200, 32767))
                                               : AW'($urandom_range(0, 19199));
        wr_data = DW'($urandom);
      end
      @(negedge mclk); #1;
      if (c % 600 == 0) begin
        jh = 10'($urandom_range(0, 799));
        jv = 10'($urandom_range(0, 524));
        jump = 1'b1;
      end
      checks++; if (wr_ack !== e_ack) begin failures++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, wr_ack, e_ack); end
      checks++; if (wr_err !== e_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, wr_err, e_err); end
      checks++; if (ram_we !== e_we) begin failures++; $display("FAIL rnd_we c=%0d got=%b want=%b", c, ram_we, e_we); end
      checks++; if (ram_addr !== e_addr) begin
        failures++; $display("FAIL rnd_addr c=%0d got=%0d want=%0d", c, ram_addr, e_addr);
      end
      if (e_we) begin
        checks++; if (ram_wdata !== wr_data) begin
          failures++; $display("FAIL rnd_wdata c=%0d got=%h want=%h", c, ram_wdata, wr_data);
        end
      end
      checks++; if (pixel_data !== e_pix) begin
        failures++; $display("FAIL rnd_pix c=%0d got=%h want=%h", c, pixel_data, e_pix);
      end
      checks++; if (pixel_en !== e_pen) begin failures++; $display("FAIL rnd_pen c=%0d got=%b want=%b", c, pixel_en, e_pen); end
      ack_prev = wr_ack;
    end
    @(posedge mclk); #1;
    wr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = DW'($urandom);
    pix0 = DW'($urandom_range(1, 255));
    pix_corner = DW'($urandom_range(1, 255));
    mem[0] = pix0;
    mem[19199] = pix_corner;
    for (int i = 0; i < FBSIZE; i++) ref_mem[i] = mem[i];
    test_reset();
    test_scan_origin();
    test_scan_corner();
`ifdef VRAM_TEAR_FREE_EN
    test_tear_free();
`else
    test_active_write();
`endif
    test_blank_b2b();
    test_oor();
    test_no_tick();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
